fc_mac_ctrl: RTL

//  FC-layer compute stage directly downstream of fc_weight_buffer. Sequences the

---
 rtl/fc_mac_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fc_mac_ctrl.sv
// fc_mac_ctrl
//   FC-layer compute stage that sits directly after fc_weight_buffer. It
//   steps the buffer's chunk address and accepts CHUNK signed features per
//   chunk. Over NUM_CHUNK chunks it accumulates NUM_OUT signed dot products,
//   then publishes every score together with the index of the largest one.
//
// Ports
//   i_clk, i_rst   rising-edge clock, synchronous active-high reset
//   i_start        starts an inference; sampled only while idle
//   i_feat         CHUNK signed features (element k = feature k of the chunk)
//   i_feat_valid   i_feat valid; accepted only while o_feat_ready is high
//   o_feat_ready   high while waiting for the current chunk of features
//   o_wbuf_addr    chunk address to the weight buffer (registered, held)
//   i_weight       weights for the addressed chunk, [neuron][k]
//   o_result       accumulated signed scores, one per neuron
//   o_class        index of the highest score (lowest index on ties)
//   o_busy         high in every state except idle
//   o_done         one-cycle pulse when o_result/o_class are fresh
module fc_mac_ctrl #(
   parameter int NUM_OUT   = 10,
   parameter int CHUNK     = 3,
   parameter int NUM_CHUNK = 3,
   parameter int DW        = 8,
   parameter int ACC_W     = 20
) (
   input  logic                                    i_clk,
   input  logic                                    i_rst,
   input  logic                                    i_start,
   input  logic [CHUNK-1:0][DW-1:0]                i_feat,
   input  logic                                    i_feat_valid,
   output logic                                    o_feat_ready,
   output logic [1:0]                              o_wbuf_addr,
   input  logic [NUM_OUT-1:0][CHUNK-1:0][DW-1:0]   i_weight,
   output logic [NUM_OUT-1:0][ACC_W-1:0]           o_result,
   output logic [3:0]                              o_class,
   output logic                                    o_busy,
   output logic                                    o_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MAC,
      S_ARGMAX,
      S_DONE
   } state_t;

   state_t                              state_q,  state_d;
   logic [1:0]                          addr_q,   addr_d;    // doubles as the chunk counter
   logic [CHUNK-1:0][DW-1:0]            feat_q,   feat_d;
   logic [NUM_OUT-1:0][ACC_W-1:0]       acc_q,    acc_d;
   logic [NUM_OUT-1:0][ACC_W-1:0]       result_q, result_d;
   logic [3:0]                          class_q,  class_d;
   logic                                ready_q,  ready_d;
   logic                                busy_q,   busy_d;
   logic                                done_q,   done_d;

   logic signed [2*DW-1:0]              prod;
   logic [NUM_OUT-1:0][ACC_W-1:0]       mac_sum;
   logic signed [ACC_W-1:0]             best_val;
   logic [3:0]                          best_idx;

   // Per-neuron chunk dot product. Each 2*DW product is sign-extended before
   // summing; CHUNK*NUM_CHUNK int8 products cannot overflow ACC_W bits.
   // NOTE: combinational blocks use blocking '=' so later statements see the
   // value just computed; clocked blocks use '<=' so every flop samples together.
   always_comb begin
      prod    = '0;
      mac_sum = '0;
      for (int n = 0; n < NUM_OUT; n++) begin
         for (int k = 0; k < CHUNK; k++) begin
            prod       = $signed(feat_q[k]) * $signed(i_weight[n][k]);
            mac_sum[n] = mac_sum[n] + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
         end
      end
   end

   // Strict '>' keeps the earliest index when scores tie.
   always_comb begin
      best_val = $signed(acc_q[0]);
      best_idx = '0;
      for (int n = 1; n < NUM_OUT; n++) begin
         if ($signed(acc_q[n]) > best_val) begin
            best_val = $signed(acc_q[n]);
            best_idx = 4'(n);
         end
      end
   end

   always_comb begin
      // NOTE: every _d starts as its _q so no path leaves a signal unassigned,
      // which would otherwise infer a latch.
      state_d  = state_q;
      addr_d   = addr_q;
      feat_d   = feat_q;
      acc_d    = acc_q;
      result_d = result_q;
      class_d  = class_q;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               acc_d    = '0;
               result_d = '0;
               addr_d   = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (i_feat_valid && ready_q) begin
               feat_d  = i_feat;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            for (int n = 0; n < NUM_OUT; n++) begin
               acc_d[n] = acc_q[n] + mac_sum[n];
            end
            if (addr_q == 2'(NUM_CHUNK-1)) begin
               state_d = S_ARGMAX;
            end else begin
               addr_d  = addr_q + 2'd1;
               state_d = S_LOAD;
            end
         end
         S_ARGMAX: begin
            result_d = acc_q;
            class_d  = best_idx;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are decoded from the next state so they are registered
      // yet line up with the state they describe.
      ready_d = (state_d == S_LOAD);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   // NOTE: accumulator and result arrays are ordinary flops, not RAM, so they
   // are reset along with the control state; an abort leaves nothing stale.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         feat_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         class_q  <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         feat_q   <= feat_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         class_q  <= class_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign o_feat_ready = ready_q;
   assign o_wbuf_addr  = addr_q;
   assign o_result     = result_q;
   assign o_class      = class_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;

endmodule
